vending_ctrl: RTL and testbench

// - Vending transaction controller; master side of the timer mode/timeout interface (drives start_timer, consumes timeout_flag).
// - Accumulates coin credit and validates product selection against per-product prices.
// - Sequences dispense and change/refund phases, each bounded by the external timer.

---
 rtl/vending_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_vending_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_ctrl.sv
// ---------------------------------------------------------------------------
// vending_ctrl
//
// Vending transaction controller. Collects coins into a credit register,
// validates product selections against fixed per-product prices, and walks
// through dispense and change/refund phases. Each non-idle phase is bounded by
// an external timer: this block requests a timer mode through start_timer and
// reacts to the timer's timeout_flag level.
//
// Ports
//   clk            in   1         clock
//   rst_n          in   1         asynchronous active-low reset
//   coin_valid     in   1         1-cycle coin strobe
//   coin_type      in   2         00=1, 01=5, 10=10, 11=20 units
//   sel_valid      in   1         1-cycle product-select strobe
//   sel_id         in   2         product id 0..3
//   cancel         in   1         1-cycle refund request
//   timeout_flag   in   1         timer level: current mode has expired
//   start_timer    out  2         timer mode: 00 none, 01 wait-select,
//                                 10 product-return, 11 change-return
//   credit         out  CREDIT_W  current credit
//   coin_reject    out  1         1-cycle pulse: coin refused
//   sel_reject     out  1         1-cycle pulse: selection refused
//   dispense_valid out  1         high for the whole dispense phase
//   dispense_id    out  2         product being dispensed
//   change_valid   out  1         high for the whole change phase
//   change_amount  out  CREDIT_W  amount being returned
// ---------------------------------------------------------------------------
module vending_ctrl #(
  parameter int CREDIT_W   = 7,
  parameter int MAX_CREDIT = 99,
  parameter int PRICE0     = 10,
  parameter int PRICE1     = 15,
  parameter int PRICE2     = 20,
  parameter int PRICE3     = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [1:0]          sel_id,
  input  logic                cancel,
  input  logic                timeout_flag,
  output logic [1:0]          start_timer,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                sel_reject,
  output logic                dispense_valid,
  output logic [1:0]          dispense_id,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount
);

  // State codes double as the timer mode codes, so start_timer is simply the
  // registered state. Every transition between two non-idle states moves to a
  // different code, which is what makes the timer reload on each phase entry.
  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_COLLECT  = 2'b01,
    S_DISPENSE = 2'b10,
    S_CHANGE   = 2'b11
  } state_t;

  localparam logic [CREDIT_W:0] MAX_CREDIT_W = (CREDIT_W+1)'(MAX_CREDIT);

  state_t state;

  // Set on the cycle a state is entered. The timer only reloads after it sees
  // the new mode code, so in that first cycle timeout_flag may still describe
  // the previous phase and must not be acted upon.
  logic arm;

  // -------------------------------------------------------------------------
  // Lookup helpers
  // -------------------------------------------------------------------------
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] ct);
    case (ct)
      2'b00:   return CREDIT_W'(1);
      2'b01:   return CREDIT_W'(5);
      2'b10:   return CREDIT_W'(10);
      default: return CREDIT_W'(20);
    endcase
  endfunction

  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] id);
    case (id)
      2'b00:   return CREDIT_W'(PRICE0);
      2'b01:   return CREDIT_W'(PRICE1);
      2'b10:   return CREDIT_W'(PRICE2);
      default: return CREDIT_W'(PRICE3);
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Collect-phase datapath
  // -------------------------------------------------------------------------
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_ok;
  logic                timeout_hit;
  logic [CREDIT_W-1:0] base_credit;
  logic [CREDIT_W:0]   sum_wide;
  logic                coin_fits;

  always_comb begin
    // NOTE: every signal gets a value at the top of the block so no path can
    // leave one unassigned, which would otherwise infer a latch.
    coin_val    = coin_value(coin_type);
    sel_price   = price_of(sel_id);
    sel_ok      = (credit >= sel_price);
    timeout_hit = timeout_flag && !arm;
    // Selection is judged on pre-coin credit; a coin in the same cycle is
    // added on top of whatever is left after the purchase.
    base_credit = credit;
    if (sel_valid && sel_ok) begin
      base_credit = credit - sel_price;
    end
    // One extra bit so the ceiling check happens before any truncation.
    sum_wide  = {1'b0, base_credit} + {1'b0, coin_val};
    coin_fits = (sum_wide <= MAX_CREDIT_W);
  end

  assign start_timer = state;

  // -------------------------------------------------------------------------
  // Transaction FSM with registered outputs
  // -------------------------------------------------------------------------
  // NOTE: reset is asynchronous, so it appears in the sensitivity list and
  // forces every output register to its idle value without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      arm            <= 1'b0;
      credit         <= '0;
      coin_reject    <= 1'b0;
      sel_reject     <= 1'b0;
      dispense_valid <= 1'b0;
      dispense_id    <= 2'b00;
      change_valid   <= 1'b0;
      change_amount  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of state and credit regardless of statement order.
      coin_reject <= 1'b0;
      sel_reject  <= 1'b0;
      arm         <= 1'b0;

      case (state)
        S_IDLE: begin
          // A single coin can never exceed the ceiling, so it is always taken.
          if (coin_valid) begin
            credit <= coin_val;
            state  <= S_COLLECT;
            arm    <= 1'b1;
          end
        end

        S_COLLECT: begin
          if (timeout_hit || cancel) begin
            // Refund everything; a coin arriving in the same cycle is handed
            // straight back rather than added to the refund.
            change_amount <= credit;
            change_valid  <= 1'b1;
            coin_reject   <= coin_valid;
            state         <= S_CHANGE;
            arm           <= 1'b1;
          end else begin
            if (sel_valid) begin
              if (sel_ok) begin
                dispense_id    <= sel_id;
                dispense_valid <= 1'b1;
                state          <= S_DISPENSE;
                arm            <= 1'b1;
              end else begin
                sel_reject <= 1'b1;
              end
            end
            if (coin_valid && coin_fits) begin
              credit <= sum_wide[CREDIT_W-1:0];
            end else begin
              credit      <= base_credit;
              coin_reject <= coin_valid;
            end
          end
        end

        S_DISPENSE: begin
          coin_reject <= coin_valid;
          if (timeout_hit) begin
            dispense_valid <= 1'b0;
            arm            <= 1'b1;
            if (credit != '0) begin
              change_amount <= credit;
              change_valid  <= 1'b1;
              state         <= S_CHANGE;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_CHANGE: begin
          coin_reject <= coin_valid;
          if (timeout_hit) begin
            credit        <= '0;
            change_amount <= '0;
            change_valid  <= 1'b0;
            state         <= S_IDLE;
            arm           <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vending_ctrl
//
// Drives vending_ctrl with directed transactions followed by a long random
// stream. A small timer model (wait 30, product 5, change 5) closes the
// start_timer/timeout_flag loop. A transaction-level model predicts every
// output and is compared against the design on each falling edge; directed
// scenarios additionally pin hand-computed values.
// ---------------------------------------------------------------------------
module tb_vending_ctrl;

  localparam int CREDIT_W = 7;
  localparam int MAX_CR   = 99;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                sel_valid;
  logic [1:0]          sel_id;
  logic                cancel;
  logic                timeout_flag;
  logic [1:0]          start_timer;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                sel_reject;
  logic                dispense_valid;
  logic [1:0]          dispense_id;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vending_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .coin_valid     (coin_valid),
    .coin_type      (coin_type),
    .sel_valid      (sel_valid),
    .sel_id         (sel_id),
    .cancel         (cancel),
    .timeout_flag   (timeout_flag),
    .start_timer    (start_timer),
    .credit         (credit),
    .coin_reject    (coin_reject),
    .sel_reject     (sel_reject),
    .dispense_valid (dispense_valid),
    .dispense_id    (dispense_id),
    .change_valid   (change_valid),
    .change_amount  (change_amount)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Timer model: reloads when the requested mode changes to a nonzero code,
  // counts down, then holds timeout_flag high until the mode changes.
  // -------------------------------------------------------------------------
  logic [1:0] t_prev;
  int         t_cnt;

  function automatic int timer_len(input logic [1:0] mode);
    case (mode)
      2'b01:   return 30;
      2'b10:   return 5;
      default: return 5;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_prev       <= 2'b00;
      t_cnt        <= 0;
      timeout_flag <= 1'b0;
    end else begin
      t_prev <= start_timer;
      if (start_timer != t_prev && start_timer != 2'b00) begin
        t_cnt        <= timer_len(start_timer);
        timeout_flag <= 1'b0;
      end else if (start_timer == 2'b00) begin
        timeout_flag <= 1'b0;
      end else if (t_cnt != 0) begin
        t_cnt <= t_cnt - 1;
      end else begin
        timeout_flag <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Transaction model. Phase numbers: 0 idle, 1 collecting, 2 dispensing,
  // 3 returning change (also the expected timer mode).
  // -------------------------------------------------------------------------
  typedef struct packed {
    int phase;
    int credit;
    int change;
    int disp;
    int crej;
    int srej;
    int fresh;
  } model_t;

  model_t m;

  function automatic int coin_units(input logic [1:0] ct);
    case (ct)
      2'b00:   return 1;
      2'b01:   return 5;
      2'b10:   return 10;
      default: return 20;
    endcase
  endfunction

  function automatic model_t model_step(input model_t s, input logic cv,
                                        input logic [1:0] ct, input logic sv,
                                        input logic [1:0] sid, input logic cn,
                                        input logic to_flag);
    model_t n;
    int     coin_amt;
    int     price;
    int     left;
    bit     expired;
    n        = s;
    n.crej   = 0;
    n.srej   = 0;
    coin_amt = coin_units(ct);
    price    = 10 + 5 * int'(sid);
    expired  = to_flag && (s.fresh == 0);
    if (s.phase == 0) begin
      if (cv) begin
        n.credit = coin_amt;
        n.phase  = 1;
      end
    end else if (s.phase == 1) begin
      if (expired || cn) begin
        n.change = s.credit;
        n.phase  = 3;
        n.crej   = int'(cv);
      end else begin
        left = s.credit;
        if (sv) begin
          if (s.credit >= price) begin
            left   = s.credit - price;
            n.disp = int'(sid);
            n.phase = 2;
          end else begin
            n.srej = 1;
          end
        end
        if (cv) begin
          if (left + coin_amt <= MAX_CR) left = left + coin_amt;
          else n.crej = 1;
        end
        n.credit = left;
      end
    end else begin
      n.crej = int'(cv);
      if (expired) begin
        if (s.phase == 2 && s.credit > 0) begin
          n.change = s.credit;
          n.phase  = 3;
        end else begin
          n.phase  = 0;
          n.credit = (s.phase == 3) ? 0 : s.credit;
          n.change = 0;
        end
      end
    end
    n.fresh = (n.phase != s.phase) ? 1 : 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= model_step(m, coin_valid, coin_type, sel_valid, sel_id, cancel,
                         timeout_flag);
  end

  // Every-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_start_timer", int'(start_timer), m.phase);
      check("m_credit", int'(credit), m.credit);
      check("m_coin_reject", int'(coin_reject), m.crej);
      check("m_sel_reject", int'(sel_reject), m.srej);
      check("m_dispense_valid", int'(dispense_valid), (m.phase == 2) ? 1 : 0);
      check("m_change_valid", int'(change_valid), (m.phase == 3) ? 1 : 0);
      check("m_change_amount", int'(change_amount), m.change);
      if (m.phase == 2) check("m_dispense_id", int'(dispense_id), m.disp);
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at a falling edge)
  // -------------------------------------------------------------------------
  task automatic do_coin(input logic [1:0] ct);
    coin_valid = 1'b1;
    coin_type  = ct;
    @(negedge clk);
    coin_valid = 1'b0;
  endtask

  task automatic do_sel(input logic [1:0] id);
    sel_valid = 1'b1;
    sel_id    = id;
    @(negedge clk);
    sel_valid = 1'b0;
  endtask

  // what: 0 dispense_valid, 1 change_valid, 2 back to idle
  task automatic wait_for(input int what, input int lim, input string name,
                          output bit saw_change_mode);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    saw_change_mode = 1'b0;
    while (!hit && n < lim) begin
      @(negedge clk);
      n++;
      if (start_timer == 2'b11) saw_change_mode = 1'b1;
      case (what)
        0:       hit = dispense_valid;
        1:       hit = change_valid;
        default: hit = (start_timer == 2'b00);
      endcase
    end
    check(name, int'(hit), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw3;
    rst_n      = 1'b0;
    coin_valid = 1'b0;
    coin_type  = 2'b00;
    sel_valid  = 1'b0;
    sel_id     = 2'b00;
    cancel     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start_timer", int'(start_timer), 0);
    check("rst_credit", int'(credit), 0);
    check("rst_dispense_valid", int'(dispense_valid), 0);
    check("rst_change_valid", int'(change_valid), 0);
    check("rst_change_amount", int'(change_amount), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1: 10 + 10, buy product 1 (15), get 5 back.
    do_coin(2'b10);
    do_coin(2'b10);
    check("s1_credit20", int'(credit), 20);
    do_sel(2'd1);
    check("s1_credit5", int'(credit), 5);
    check("s1_dispense_valid", int'(dispense_valid), 1);
    check("s1_dispense_id", int'(dispense_id), 1);
    check("s1_timer_product", int'(start_timer), 2);
    wait_for(1, 20, "s1_reach_change", saw3);
    check("s1_change_amount", int'(change_amount), 5);
    check("s1_timer_change", int'(start_timer), 3);
    wait_for(2, 20, "s1_reach_idle", saw3);
    check("s1_idle_credit", int'(credit), 0);

    // Scenario 2: exact payment for product 2, no change phase.
    do_coin(2'b11);
    do_sel(2'd2);
    check("s2_dispense_id", int'(dispense_id), 2);
    check("s2_credit0", int'(credit), 0);
    wait_for(2, 20, "s2_reach_idle", saw3);
    check("s2_no_change_mode", int'(saw3), 0);
    // Scenario 3: immediate new coin; stale flag must not end collecting.
    do_coin(2'b01);
    check("s3_collect", int'(start_timer), 1);
    check("s3_credit5", int'(credit), 5);
    do_sel(2'd3);
    check("s3_sel_reject", int'(sel_reject), 1);
    check("s3_credit_kept", int'(credit), 5);
    @(negedge clk);
    check("s3_sel_reject_pulse", int'(sel_reject), 0);
    check("s3_still_collect", int'(start_timer), 1);

    // Scenario 4: no selection, wait expiry refunds 5.
    wait_for(1, 60, "s4_reach_change", saw3);
    check("s4_change_amount", int'(change_amount), 5);
    check("s4_timer_change", int'(start_timer), 3);
    wait_for(2, 20, "s4_reach_idle", saw3);
    check("s4_idle_credit", int'(credit), 0);

    // Scenario 5: ceiling rejection, then cancel beats same-cycle selection.
    repeat (4) do_coin(2'b11);
    do_coin(2'b10);
    check("s5_credit90", int'(credit), 90);
    do_coin(2'b11);
    check("s5_coin_reject", int'(coin_reject), 1);
    check("s5_credit_held", int'(credit), 90);
    cancel    = 1'b1;
    sel_valid = 1'b1;
    sel_id    = 2'd0;
    @(negedge clk);
    cancel    = 1'b0;
    sel_valid = 1'b0;
    check("s5_change_valid", int'(change_valid), 1);
    check("s5_change_amount", int'(change_amount), 90);
    check("s5_no_dispense", int'(dispense_valid), 0);
    wait_for(2, 20, "s5_reach_idle", saw3);

    // Scenario 6: asynchronous reset during dispense.
    do_coin(2'b11);
    do_sel(2'd0);
    check("s6_dispensing", int'(dispense_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_async_timer", int'(start_timer), 0);
    check("s6_async_credit", int'(credit), 0);
    check("s6_async_dispense", int'(dispense_valid), 0);
    check("s6_async_id", int'(dispense_id), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("s6_idle_after", int'(start_timer), 0);

    // Random stream, including occasional resets.
    for (int i = 0; i < 4000; i++) begin
      coin_valid = ($urandom_range(0, 3) == 0);
      coin_type  = 2'($urandom_range(0, 3));
      sel_valid  = ($urandom_range(0, 7) == 0);
      sel_id     = 2'($urandom_range(0, 3));
      cancel     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    coin_valid = 1'b0;
    sel_valid  = 1'b0;
    cancel     = 1'b0;
    repeat (60) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
